// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one streaming bus among NUM_REQ requesters.
// A grant is held for a whole burst, which ends on a last beat or at MAX_BURST beats.
module bus_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  output logic [BUS_WIDTH-1:0]           out_data,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           overrun
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] PTR_RESET = IW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [IW-1:0]        last_ptr_q, last_ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                 overrun_q, overrun_d;

  logic [IW-1:0]        sel_idx;
  logic                 sel_found;
  logic                 g_valid;
  logic                 g_last;
  logic [BUS_WIDTH-1:0] g_data;
  logic                 cap_hit;
  logic                 beat_acc;
  logic                 burst_end;

  // Search last_ptr+1, last_ptr+2, ... modulo NUM_REQ; walking the offsets
  // downwards lets the nearest asserted requester overwrite farther ones.
  always_comb begin
    int cand;
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(last_ptr_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_valid[cand]) begin
        sel_idx   = IW'(cand);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IW'(i)) g_data = req_data[i*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  assign g_valid = req_valid[gidx_q];
  assign g_last  = req_last[gidx_q];
  assign cap_hit = (beat_cnt_q == CNT_LAST);

  // Handshake: a beat moves when out_valid && out_ready in the same cycle;
  // out_valid never depends on out_ready, and only the granted requester sees ready.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    if (state_q == GRANT) begin
      out_valid         = g_valid;
      out_data          = g_data;
      out_last          = g_last | cap_hit;
      req_ready[gidx_q] = out_ready;
    end
  end

  assign beat_acc  = (state_q == GRANT) && g_valid && out_ready;
  assign burst_end = beat_acc && out_last;

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    beat_cnt_d = beat_cnt_q;
    overrun_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = GRANT;
          gidx_d     = sel_idx;
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (burst_end) begin
          state_d    = IDLE;
          last_ptr_d = gidx_q;
          grant_d    = '0;
          beat_cnt_d = '0;
          overrun_d  = cap_hit & ~g_last;
        end else if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gidx_q     <= '0;
      last_ptr_q <= PTR_RESET;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      last_ptr_q <= last_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == GRANT);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: per-requester beat buffers feed the DUT, and a
// scoreboard of expected {grant, last, data} beats is checked on every transfer.
module tb_bus_rr_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int MB    = 16;
  localparam int EW    = N + 1 + W;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             out_ready;
  logic [N-1:0]     grant;
  logic             busy;
  logic             overrun;

  logic [W-1:0]     src_data [N][DEPTH];
  logic             src_last [N][DEPTH];
  int               head [N];
  int               tail [N];
  logic [N-1:0]     hold;
  logic [N-1:0]     acc_mask;
  logic [EW-1:0]    exp_q [$];
  int               compared = 0;
  int               mismatched = 0;
  int               ov_total = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bus_rr_arbiter #(.NUM_REQ(N), .BUS_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Requester model: advance past beats accepted at this edge, then present the next one.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i] && head[i] < tail[i]) head[i] = head[i] + 1;
      if (head[i] < tail[i] && !hold[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = src_data[i][head[i] % DEPTH];
        req_last[i]        = src_last[i][head[i] % DEPTH];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // Scoreboard: every transferred beat pops one expected entry.
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    acc_mask = req_valid & req_ready;
    if (rst_n && overrun) ov_total++;
    if (rst_n && out_valid && out_ready) begin
      act_v = {grant, out_last, out_data};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL beat_unexpected: got %h, required no beat", act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          mismatched++;
          $display("FAIL scoreboard_beat: got {grant,last,data}=%h, required %h", act_v, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input int r, input int n, input int last_every, output int base);
    base = tail[r];
    for (int k = 0; k < n; k++) begin
      src_data[r][(base + k) % DEPTH] = $urandom;
      src_last[r][(base + k) % DEPTH] = ((k + 1) % last_every == 0);
    end
    tail[r] = base + n;
  endtask

  task automatic push_exp(input int r, input int idx, input logic last);
    logic [N-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    exp_q.push_back({oh, last, src_data[r][idx % DEPTH]});
  endtask

  task automatic flush_sources();
    for (int i = 0; i < N; i++) tail[i] = head[i];
    hold = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    flush_sources();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    compared++; if (grant !== '0) begin mismatched++; $display("FAIL reset_grant: got %b, required 0", grant); end
    compared++; if ({busy, overrun} !== 2'b00) begin mismatched++; $display("FAIL reset_busy_overrun: got %b, required 00", {busy, overrun}); end
    compared++; if ({out_valid, out_last} !== 2'b00) begin mismatched++; $display("FAIL reset_out_flags: got %b, required 00", {out_valid, out_last}); end
    compared++; if (out_data !== '0) begin mismatched++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    compared++; if (req_ready !== '0) begin mismatched++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      if ({busy, grant, out_valid, req_ready} !== '0) begin
        mismatched++;
        $display("FAIL idle_no_request: got %b, required 0", {busy, grant, out_valid, req_ready});
      end
    end
  endtask

  task automatic test_rr_single();
    int b1, b2;
    logic e;
    do_reset();
    @(posedge clk); #1;
    load(1, 2, 1, b1);
    load(2, 2, 1, b2);
    push_exp(1, b1, 1'b1);
    push_exp(2, b2, 1'b1);
    push_exp(1, b1 + 1, 1'b1);
    push_exp(2, b2 + 1, 1'b1);
    @(negedge clk);
    compared++; if ({out_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL rr_idle_first: got %b, required 00", {out_valid, busy}); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = (k % 2 == 0);
      compared++;
      if ({out_valid, busy} !== {e, e}) begin
        mismatched++;
        $display("FAIL rr_single_timing: cycle %0d got %b, required %b", k, {out_valid, busy}, {e, e});
      end
    end
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL rr_single_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_all_four();
    int b[N];
    int ov0;
    logic e;
    do_reset();
    ov0 = ov_total;
    @(posedge clk); #1;
    load(0, 6, 3, b[0]);
    for (int r = 1; r < N; r++) load(r, 3, 3, b[r]);
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 3; k++) push_exp(r, b[r] + k, k == 2);
    for (int k = 0; k < 3; k++) push_exp(0, b[0] + 3 + k, k == 2);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      e = (k % 4 != 3);
      compared++;
      if ({out_valid, busy} !== {e, e}) begin
        mismatched++;
        $display("FAIL burst3_timing: cycle %0d got %b, required %b", k, {out_valid, busy}, {e, e});
      end
    end
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL burst3_drain: got %0d left, required 0", exp_q.size()); end
    compared++; if (ov_total - ov0 != 0) begin mismatched++; $display("FAIL burst3_no_overrun: got %0d pulses, required 0", ov_total - ov0); end
  endtask

  task automatic test_overrun();
    int b, acc, ov_hits, ov_right;
    logic prev16;
    do_reset();
    @(posedge clk); #1;
    load(2, 20, 20, b);
    for (int k = 0; k < 20; k++) push_exp(2, b + k, (k == MB - 1) || (k == 19));
    acc = 0; ov_hits = 0; ov_right = 0; prev16 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (overrun) begin
        ov_hits++;
        if (prev16) ov_right++;
      end
      if (prev16) begin
        compared++;
        if ({out_valid, busy, grant} !== '0) begin
          mismatched++;
          $display("FAIL overrun_release: got %b, required 0", {out_valid, busy, grant});
        end
      end
      prev16 = 1'b0;
      if (out_valid && out_ready) begin
        acc++;
        if (acc == MB) prev16 = 1'b1;
      end
    end
    compared++; if (ov_hits != 1) begin mismatched++; $display("FAIL overrun_count: got %0d, required 1", ov_hits); end
    compared++; if (ov_right != 1) begin mismatched++; $display("FAIL overrun_timing: got %0d, required 1", ov_right); end
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL overrun_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    int b0, b3, acc;
    do_reset();
    @(posedge clk); #1;
    load(0, 4, 4, b0);
    load(3, 1, 1, b3);
    for (int k = 0; k < 4; k++) push_exp(0, b0 + k, k == 3);
    push_exp(3, b3, 1'b1);
    acc = 0;
    for (int k = 0; k < 20 && acc < 2; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) acc++;
    end
    compared++; if (acc != 2) begin mismatched++; $display("FAIL hold_setup: got %0d beats, required 2", acc); end
    @(posedge clk); #1;
    hold[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, grant, req_ready[3], busy} !== {1'b0, N'(1), 1'b0, 1'b1}) begin
        mismatched++;
        $display("FAIL hold_grant: cycle %0d got %b, required %b", k,
                 {out_valid, grant, req_ready[3], busy}, {1'b0, N'(1), 1'b0, 1'b1});
      end
    end
    @(posedge clk); #1;
    hold[0] = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL hold_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int b;
    logic [W-1:0] d0;
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    load(1, 2, 2, b);
    push_exp(1, b, 1'b0);
    push_exp(1, b + 1, 1'b1);
    d0 = src_data[1][b % DEPTH];
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, out_last, grant, req_ready, out_data} !== {1'b1, 1'b0, N'(2), N'(0), d0}) begin
        mismatched++;
        $display("FAIL stall_hold: cycle %0d got %h, required %h", k,
                 {out_valid, out_last, grant, req_ready, out_data}, {1'b1, 1'b0, N'(2), N'(0), d0});
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL stall_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int b, acc;
    do_reset();
    @(posedge clk); #1;
    load(1, 4, 4, b);
    push_exp(1, b, 1'b0);
    acc = 0;
    for (int k = 0; k < 20 && acc < 1; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) acc++;
    end
    @(posedge clk); #3;
    compared++; if ({out_valid, busy} !== 2'b11) begin mismatched++; $display("FAIL midburst_beat2: got %b, required 11", {out_valid, busy}); end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({grant, busy, out_valid, out_last, req_ready} !== '0) begin
      mismatched++;
      $display("FAIL async_reset: got %b, required 0", {grant, busy, out_valid, out_last, req_ready});
    end
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL reset_partial: got %0d left, required 0", exp_q.size()); end
    flush_sources();
    load(0, 1, 1, b);
    push_exp(0, b, 1'b1);
    load(3, 1, 1, b);
    push_exp(3, b, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    compared++; if ({busy, grant} !== '0) begin mismatched++; $display("FAIL post_reset_idle: got %b, required 0", {busy, grant}); end
    @(negedge clk);
    compared++; if (grant !== N'(1)) begin mismatched++; $display("FAIL post_reset_winner: got %b, required %b", grant, N'(1)); end
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL post_reset_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    hold      = '0;
    acc_mask  = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    test_reset();
    test_rr_single();
    test_all_four();
    test_overrun();
    test_hold();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter that shares one BUS_WIDTH-wide streaming bus among NUM_REQ requesters.
- Grants one requester at a time and holds the grant for a whole burst, ended by a beat marked last.
- Enforces a maximum burst length and muxes data, valid and last from the granted requester onto the shared output.
- Sits between requester-side masters and a single downstream bus port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- BUS_WIDTH, 32, data width of each requester and of the shared bus.
- MAX_BURST, 16, maximum beats per grant (1..256); the counter width is $clog2(MAX_BURST+1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*BUS_WIDTH  flattened data; requester i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- req_last  input  NUM_REQ  per-requester last-beat flag.
- req_ready  output  NUM_REQ  per-requester ready.
- out_valid  output  1  shared bus valid.
- out_data  output  BUS_WIDTH  shared bus data.
- out_last  output  1  shared bus last.
- out_ready  input  1  downstream ready.
- grant  output  NUM_REQ  one-hot current grant; all zero when idle.
- busy  output  1  high while in GRANT state.
- overrun  output  1  one-cycle pulse when a burst is truncated at MAX_BURST.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - state=IDLE, grant=0, busy=0, overrun=0, beat_cnt=0.
  - last_ptr=NUM_REQ-1, so requester 0 has top priority first.
  - out_valid=0, out_last=0, out_data=0, req_ready=0.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If any req_valid, select the first asserted index searching last_ptr+1, last_ptr+2, ... modulo NUM_REQ.
  - Register the selection into grant, go to GRANT, clear beat_cnt.
  - If no req_valid, stay in IDLE.
- GRANT:
  - Outputs are combinational from the granted index g: out_valid=req_valid[g], out_data=req_data[g], req_ready[g]=out_ready.
  - All other req_ready bits are 0.
  - A beat is accepted when out_valid && out_ready; each accepted beat increments beat_cnt.
  - Effective last: out_last = req_last[g] OR (beat_cnt == MAX_BURST-1).
  - On an accepted beat with out_last=1:
    - next state IDLE, last_ptr=g, grant=0, beat_cnt=0.
    - overrun pulses for one cycle (the cycle after the accepted beat) iff the truncation term forced last while req_last[g]=0.
- Latency:
  - req_valid in IDLE leads to out_valid one cycle later.
  - Exactly one idle bubble cycle follows each burst before the next grant.
  - Single-beat burst with out_ready held high: 2 cycles per burst.
- Grant hold:
  - The grant is never revoked mid-burst.
  - If the granted requester drops req_valid, out_valid=0 and the grant persists until last is accepted.
- Requesters not granted see req_ready=0; they must hold their valid and data, and the arbiter does not check this.
- Fairness: a requester asserting valid continuously waits at most NUM_REQ-1 bursts.
- Simultaneous events:
  - A requester raising valid in the same cycle a burst ends is eligible in the following IDLE cycle.
  - The pointer update uses the just-finished g.
- With MAX_BURST=1, every beat is last and overrun pulses whenever req_last=0.
- Reset mid-burst returns immediately to IDLE with the reset values above; the partial burst is abandoned and no last is emitted.
- All outputs are glitch-free relative to registered state plus the listed combinational input paths; no combinational path runs from out_ready to out_valid.

Test Plan:
- Reset, then req_valid=4'b0110 with single-beat bursts and out_ready=1 -> grant 4'b0010 then 4'b0100, then back to 4'b0010; each out_valid appears 1 cycle after IDLE.
- All four requesters hold valid with 3-beat bursts (last on beat 3) -> grant order 0,1,2,3,0; each burst passes 3 beats on out_data matching the source; 1 bubble between bursts.
- Requester 2 sends a 20-beat burst with last only at beat 20, MAX_BURST=16 -> out_last=1 on beat 16, overrun pulses once, grant released; remaining beats go out as a new burst after arbitration.
- Granted requester drops valid for 5 cycles mid-burst while requester 3 is valid -> grant stays on the original requester, out_valid=0 for those cycles, requester 3 keeps req_ready=0.
- out_ready=0 for 10 cycles with beat 1 pending -> out_data stable, beat_cnt unchanged, no acceptance; transfer completes once out_ready=1.
- Assert rst_n=0 mid-burst at beat 2 -> grant=0, busy=0, out_valid=0 asynchronously; after release, requester 0 wins against simultaneous requests from 0 and 3.
